timer_counter: RTL

- 64-bit free-running counter with prescaler, feeding `cnt` to the downstream interrupt compare stage of the 64-bit timer.
- Software can write either 32-bit half through byte-strobed register writes.
- Optional clock division by 2^div_val.
- Freezes on an acknowledged debug halt.

---
 rtl/timer_counter.sv | 106 ++++++++++
 1 files changed

// File: rtl/timer_counter.sv
// rtl/timer_counter.sv - 64-bit free-running timer counter with prescaler, byte-strobed writes and debug halt
module timer_counter #(
   parameter int DIV_MAX = 8,
   parameter int PRE_W   = 8
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic        timer_en,
   input  logic        div_en,
   input  logic [3:0]  div_val,
   input  logic        dbg_mode,
   input  logic        halt_req,
   input  logic        tdr0_wr_sel,
   input  logic        tdr1_wr_sel,
   input  logic [31:0] wdata,
   input  logic [3:0]  pstrb,
   output logic [63:0] cnt,
   output logic        cnt_en,
   output logic        halt_ack
);

   localparam logic [3:0] DIV_MAX_W = 4'(DIV_MAX);

   logic [PRE_W-1:0] prescaler;
   logic             timer_en_d;
   logic [3:0]       eff_div;
   logic [PRE_W:0]   one_sh;
   logic [PRE_W-1:0] limit;
   logic             wr_any;
   logic             pre_at_limit;
   logic             undivided;
   logic [31:0]      merged_lo;
   logic [31:0]      merged_hi;

   // Clamp the exponent and derive the terminal prescaler value for this cycle.
   always_comb begin
      eff_div = (div_val > DIV_MAX_W) ? DIV_MAX_W : div_val;
      one_sh  = {{PRE_W{1'b0}}, 1'b1} << eff_div;
      limit   = PRE_W'(one_sh - 1'b1);
   end

   // Increment qualifier: a register write always wins over counting in its cycle.
   always_comb begin
      wr_any       = tdr0_wr_sel | tdr1_wr_sel;
      pre_at_limit = (prescaler == limit);
      undivided    = ~div_en | (eff_div == 4'd0);
      cnt_en       = timer_en & ~halt_ack & ~wr_any & (undivided | pre_at_limit);
   end

   // Byte-lane merge of write data into each counter half.
   always_comb begin
      merged_lo = cnt[31:0];
      merged_hi = cnt[63:32];
      for (int i = 0; i < 4; i++) begin
         if (pstrb[i]) begin
            merged_lo[8*i +: 8] = wdata[8*i +: 8];
            merged_hi[8*i +: 8] = wdata[8*i +: 8];
         end
      end
   end

   // Halt acknowledge and enable history, both one cycle behind their inputs.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         halt_ack   <= 1'b0;
         timer_en_d <= 1'b0;
      end else begin
         halt_ack   <= halt_req & dbg_mode;
         timer_en_d <= timer_en;
      end
   end

   // Prescaler: cleared when idle, frozen while halted so the phase survives a halt.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         prescaler <= '0;
      end else if (!timer_en || !div_en) begin
         prescaler <= '0;
      end else if (halt_ack) begin
         prescaler <= prescaler;
      end else if (pre_at_limit) begin
         prescaler <= '0;
      end else begin
         prescaler <= prescaler + PRE_W'(1);
      end
   end

   // Counter: write, then clear on enable falling edge, then increment, else hold.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         cnt <= '0;
      end else if (wr_any) begin
         if (tdr0_wr_sel) begin
            cnt[31:0] <= merged_lo;
         end
         if (tdr1_wr_sel) begin
            cnt[63:32] <= merged_hi;
         end
      end else if (timer_en_d && !timer_en) begin
         cnt <= '0;
      end else if (cnt_en) begin
         cnt <= cnt + 64'd1;
      end
   end

endmodule
